// File: rtl/smc_mem_responder_lite16.sv
// -----------------------------------------------------------------------------
// smc_mem_responder_lite16
//
// Memory-side responder for a static memory controller bus. Holds a small
// 2**AW x DW register-file memory and answers chip-select / output-enable /
// write-enable strobes from the controller with a configurable read latency.
//
// Ports
//   sys_clk16         in   system clock, rising edge
//   n_sys_reset16     in   asynchronous active-low reset
//   smc_n_cs16        in   chip select, active-low
//   smc_n_oe16        in   read strobe, active-low
//   smc_n_we16        in   write strobe, active-low
//   smc_n_be16        in   byte lanes, active-low (DW/8 bits)
//   smc_addr16        in   word address (AW bits)
//   smc_data_out16    in   write data from controller (DW bits)
//   smc_data_in16     out  read data to controller, zero unless valid
//   rsp_data_valid16  out  read data valid
//   rsp_state16       out  registered state: 0 IDLE, 1 SELECT, 2 READ, 3 WRITE
//   rsp_err16         out  sticky protocol error
//   err_clr16         in   clears rsp_err16 (a same-cycle set wins)
// -----------------------------------------------------------------------------
module smc_mem_responder_lite16 #(
    parameter int unsigned AW     = 4,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              sys_clk16,
    input  logic              n_sys_reset16,
    input  logic              smc_n_cs16,
    input  logic              smc_n_oe16,
    input  logic              smc_n_we16,
    input  logic [DW/8-1:0]   smc_n_be16,
    input  logic [AW-1:0]     smc_addr16,
    input  logic [DW-1:0]     smc_data_out16,
    output logic [DW-1:0]     smc_data_in16,
    output logic              rsp_data_valid16,
    output logic [1:0]        rsp_state16,
    output logic              rsp_err16,
    input  logic              err_clr16
);

    localparam int unsigned NumBytes = DW / 8;
    localparam int unsigned NumWords = 2 ** AW;
    localparam logic [2:0]  LatInit  = 3'(RD_LAT);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSelect = 2'd1,
        StRead   = 2'd2,
        StWrite  = 2'd3
    } state_e;

    state_e              r_state;
    state_e              w_state_nxt;
    logic [2:0]          r_cnt;
    logic [2:0]          w_cnt_nxt;

    // Write capture registers; committed to memory when the write strobe ends.
    logic [AW-1:0]       r_wr_addr;
    logic [DW-1:0]       r_wr_data;
    logic [NumBytes-1:0] r_wr_be;
    logic                r_wr_abort;
    logic                w_wr_abort_nxt;

    logic                w_capture;
    logic                w_commit;
    logic                w_rd_fire;
    logic                w_err_set;

    logic [DW-1:0]       r_mem [NumWords];
    logic [DW-1:0]       r_rd_data;
    logic                r_rd_valid;
    logic                r_err;

    // -------------------------------------------------------------------------
    // Next-state and control decode
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_wr_abort_nxt = r_wr_abort;
        w_capture      = 1'b0;
        w_commit       = 1'b0;
        w_rd_fire      = 1'b0;
        w_err_set      = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (!smc_n_cs16) begin
                    w_state_nxt = StSelect;
                end
            end

            StSelect: begin
                if (smc_n_cs16) begin
                    w_state_nxt = StIdle;
                end else if (!smc_n_oe16 && smc_n_we16) begin
                    w_state_nxt = StRead;
                    w_cnt_nxt   = LatInit;
                end else if (!smc_n_we16 && smc_n_oe16) begin
                    // The bus already carries the write beat on the strobe's
                    // first cycle, so capture it on the way into WRITE.
                    w_state_nxt    = StWrite;
                    w_capture      = 1'b1;
                    w_wr_abort_nxt = 1'b0;
                end else if (!smc_n_we16 && !smc_n_oe16) begin
                    w_err_set = 1'b1;
                end
            end

            StRead: begin
                if (smc_n_oe16 || smc_n_cs16) begin
                    w_state_nxt = smc_n_cs16 ? StIdle : StSelect;
                    w_cnt_nxt   = 3'd0;
                    // Strobe released before the latency elapsed.
                    if (r_cnt != 3'd0) begin
                        w_err_set = 1'b1;
                    end
                end else if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else begin
                    w_rd_fire = 1'b1;
                end
            end

            StWrite: begin
                if (smc_n_we16 || smc_n_cs16) begin
                    w_state_nxt    = smc_n_cs16 ? StIdle : StSelect;
                    w_commit       = !r_wr_abort;
                    w_wr_abort_nxt = 1'b0;
                end else if (!smc_n_oe16) begin
                    // Conflicting strobes poison the whole write.
                    w_err_set      = 1'b1;
                    w_wr_abort_nxt = 1'b1;
                end else begin
                    w_capture = 1'b1;
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State, counter, capture and response registers
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            r_state    <= StIdle;
            r_cnt      <= 3'd0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_be    <= '0;
            r_wr_abort <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wr_abort <= w_wr_abort_nxt;
            if (w_capture) begin
                r_wr_addr <= smc_addr16;
                r_wr_data <= smc_data_out16;
                r_wr_be   <= smc_n_be16;
            end
        end
    end

    // Read data register is zeroed in every cycle that does not deliver data,
    // which keeps the output at 0 whenever valid is low.
    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_fire) begin
            r_rd_data  <= r_mem[smc_addr16];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (err_clr16) begin
            r_err <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Storage: byte-lane write on commit, whole array cleared by reset
    // -------------------------------------------------------------------------
    always_ff @(posedge sys_clk16 or negedge n_sys_reset16) begin
        if (!n_sys_reset16) begin
            for (int w = 0; w < int'(NumWords); w++) begin
                r_mem[w] <= '0;
            end
        end else if (w_commit) begin
            for (int b = 0; b < int'(NumBytes); b++) begin
                if (!r_wr_be[b]) begin
                    r_mem[r_wr_addr][b*8 +: 8] <= r_wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign smc_data_in16    = r_rd_data;
    assign rsp_data_valid16 = r_rd_valid;
    assign rsp_state16      = r_state;
    assign rsp_err16        = r_err;

endmodule

// File: tb/tb_smc_mem_responder_lite16.sv
// -----------------------------------------------------------------------------
// tb_smc_mem_responder_lite16
//
// Self-checking bench for smc_mem_responder_lite16 (AW=4, DW=32, RD_LAT=2).
// Directed vector table, hand sequences for error/reset corners, and a random
// read/write mix checked against a word-array memory model.
// -----------------------------------------------------------------------------
module tb_smc_mem_responder_lite16;

    localparam int AW     = 4;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          sys_clk16 = 1'b0;
    logic          n_sys_reset16;
    logic          smc_n_cs16;
    logic          smc_n_oe16;
    logic          smc_n_we16;
    logic [3:0]    smc_n_be16;
    logic [AW-1:0] smc_addr16;
    logic [DW-1:0] smc_data_out16;
    logic [DW-1:0] smc_data_in16;
    logic          rsp_data_valid16;
    logic [1:0]    rsp_state16;
    logic          rsp_err16;
    logic          err_clr16;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [16];

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    smc_mem_responder_lite16 #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) u_dut (
        .sys_clk16        (sys_clk16),
        .n_sys_reset16    (n_sys_reset16),
        .smc_n_cs16       (smc_n_cs16),
        .smc_n_oe16       (smc_n_oe16),
        .smc_n_we16       (smc_n_we16),
        .smc_n_be16       (smc_n_be16),
        .smc_addr16       (smc_addr16),
        .smc_data_out16   (smc_data_out16),
        .smc_data_in16    (smc_data_in16),
        .rsp_data_valid16 (rsp_data_valid16),
        .rsp_state16      (rsp_state16),
        .rsp_err16        (rsp_err16),
        .err_clr16        (err_clr16)
    );

    always #5 sys_clk16 = ~sys_clk16;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk16);
        #1;
    endtask

    // Byte-enable merge: active-low lane bits select bytes of new data.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (!be[b]) r[b*8 +: 8] = d[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic idle_inputs();
        smc_n_cs16     = 1'b1;
        smc_n_oe16     = 1'b1;
        smc_n_we16     = 1'b1;
        smc_n_be16     = 4'hF;
        smc_addr16     = '0;
        smc_data_out16 = '0;
        err_clr16      = 1'b0;
    endtask

    // Single-beat write; starts and ends in SELECT with chip select held low.
    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        smc_n_we16     = 1'b0;
        smc_addr16     = a;
        smc_data_out16 = d;
        smc_n_be16     = be;
        tick();
        chk("wr_state_write", 32'(rsp_state16), 32'd3);
        smc_n_we16 = 1'b1;
        smc_n_be16 = 4'hF;
        tick();
        chk("wr_state_select", 32'(rsp_state16), 32'd1);
        model[a] = merge(model[a], d, be);
    endtask

    // Read: valid must appear exactly RD_LAT+1 cycles after READ entry, then
    // data follows an address change with one cycle of latency.
    task automatic do_read(input logic [3:0] a, input logic [31:0] exp,
                           input logic [3:0] a2, input logic [31:0] exp2);
        smc_n_oe16 = 1'b0;
        smc_addr16 = a;
        tick();
        chk("rd_state_read", 32'(rsp_state16), 32'd2);
        chk("rd_entry_valid", 32'(rsp_data_valid16), 32'd0);
        for (int i = 0; i < RD_LAT; i++) begin
            tick();
            chk("rd_wait_valid", 32'(rsp_data_valid16), 32'd0);
            chk("rd_wait_data", smc_data_in16, 32'h0);
        end
        tick();
        chk("rd_valid", 32'(rsp_data_valid16), 32'd1);
        chk("rd_data", smc_data_in16, exp);
        smc_addr16 = a2;
        tick();
        chk("rd_follow_data", smc_data_in16, exp2);
        smc_n_oe16 = 1'b1;
        tick();
        chk("rd_exit_state", 32'(rsp_state16), 32'd1);
        chk("rd_exit_valid", 32'(rsp_data_valid16), 32'd0);
        chk("rd_exit_data", smc_data_in16, 32'h0);
    endtask

    initial begin
        logic [3:0]  ra;
        logic [3:0]  ra2;
        logic [31:0] rd;
        logic [3:0]  rbe;

        vecs[0] = '{1'b1, 4'd3,  32'hA5A5_1234, 4'b0000, 32'h0};
        vecs[1] = '{1'b0, 4'd3,  32'h0,         4'b0000, 32'hA5A5_1234};
        vecs[2] = '{1'b1, 4'd5,  32'hFFFF_FFFF, 4'b0000, 32'h0};
        vecs[3] = '{1'b1, 4'd5,  32'h0000_0000, 4'b1110, 32'h0};
        vecs[4] = '{1'b0, 4'd5,  32'h0,         4'b0000, 32'hFFFF_FF00};
        vecs[5] = '{1'b1, 4'd7,  32'h1234_5678, 4'b0101, 32'h0};
        vecs[6] = '{1'b0, 4'd7,  32'h0,         4'b0000, 32'h1200_5600};
        vecs[7] = '{1'b0, 4'd0,  32'h0,         4'b0000, 32'h0};
        vecs[8] = '{1'b1, 4'd15, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        vecs[9] = '{1'b0, 4'd15, 32'h0,         4'b0000, 32'hDEAD_BEEF};

        idle_inputs();
        clear_model();
        n_sys_reset16 = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(rsp_state16), 32'd0);
        chk("rst_valid", 32'(rsp_data_valid16), 32'd0);
        chk("rst_data", smc_data_in16, 32'h0);
        chk("rst_err", 32'(rsp_err16), 32'd0);

        n_sys_reset16 = 1'b1;
        tick();
        chk("idle_hold", 32'(rsp_state16), 32'd0);
        smc_n_cs16 = 1'b0;
        tick();
        chk("idle_to_select", 32'(rsp_state16), 32'd1);

        // Directed table; chip select stays low throughout (back-to-back).
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].be);
            end else begin
                do_read(vecs[i].addr, vecs[i].exp, vecs[i].addr, vecs[i].exp);
            end
        end
        chk("no_err_after_table", 32'(rsp_err16), 32'd0);

        // Early read termination.
        smc_n_oe16 = 1'b0;
        smc_addr16 = 4'd3;
        tick();
        chk("early_state_read", 32'(rsp_state16), 32'd2);
        smc_n_oe16 = 1'b1;
        tick();
        chk("early_err", 32'(rsp_err16), 32'd1);
        chk("early_state_select", 32'(rsp_state16), 32'd1);
        chk("early_valid0", 32'(rsp_data_valid16), 32'd0);
        tick();
        chk("early_valid1", 32'(rsp_data_valid16), 32'd0);
        chk("early_err_sticky", 32'(rsp_err16), 32'd1);
        err_clr16 = 1'b1;
        tick();
        err_clr16 = 1'b0;
        chk("err_clear", 32'(rsp_err16), 32'd0);

        // Both strobes low with a simultaneous clear: set wins.
        smc_n_oe16 = 1'b0;
        smc_n_we16 = 1'b0;
        err_clr16  = 1'b1;
        tick();
        chk("both_err_set_wins", 32'(rsp_err16), 32'd1);
        chk("both_state", 32'(rsp_state16), 32'd1);
        smc_n_oe16 = 1'b1;
        smc_n_we16 = 1'b1;
        tick();
        err_clr16 = 1'b0;
        chk("both_err_clr", 32'(rsp_err16), 32'd0);

        // Read strobe during a write: error, write dropped.
        smc_n_we16     = 1'b0;
        smc_addr16     = 4'd3;
        smc_data_out16 = 32'h1111_1111;
        smc_n_be16     = 4'h0;
        tick();
        chk("wconf_state_write", 32'(rsp_state16), 32'd3);
        smc_n_oe16 = 1'b0;
        tick();
        chk("wconf_err", 32'(rsp_err16), 32'd1);
        smc_n_oe16 = 1'b1;
        smc_n_we16 = 1'b1;
        smc_n_be16 = 4'hF;
        tick();
        chk("wconf_state_select", 32'(rsp_state16), 32'd1);
        do_read(4'd3, model[3], 4'd3, model[3]);
        err_clr16 = 1'b1;
        tick();
        err_clr16 = 1'b0;

        // Random mix against the model.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                rd  = $urandom;
                rbe = 4'($urandom_range(0, 15));
                do_write(ra, rd, rbe);
            end else begin
                ra2 = 4'($urandom_range(0, 15));
                do_read(ra, model[ra], ra2, model[ra2]);
            end
        end
        chk("no_err_after_random", 32'(rsp_err16), 32'd0);

        // Reset during a read with valid high clears valid at once.
        smc_n_oe16 = 1'b0;
        smc_addr16 = 4'd5;
        tick();
        for (int i = 0; i <= RD_LAT; i++) tick();
        chk("midrd_valid_before", 32'(rsp_data_valid16), 32'd1);
        n_sys_reset16 = 1'b0;
        #1;
        chk("midrd_valid_async", 32'(rsp_data_valid16), 32'd0);
        chk("midrd_data_async", smc_data_in16, 32'h0);
        chk("midrd_state_async", 32'(rsp_state16), 32'd0);
        clear_model();
        idle_inputs();
        tick();
        n_sys_reset16 = 1'b1;
        tick();

        // Reset during a write drops the pending commit.
        smc_n_cs16 = 1'b0;
        tick();
        smc_n_we16     = 1'b0;
        smc_addr16     = 4'd9;
        smc_data_out16 = 32'hCAFE_F00D;
        smc_n_be16     = 4'h0;
        tick();
        chk("midwr_state_write", 32'(rsp_state16), 32'd3);
        n_sys_reset16 = 1'b0;
        #1;
        chk("midwr_state_async", 32'(rsp_state16), 32'd0);
        idle_inputs();
        tick();
        n_sys_reset16 = 1'b1;
        tick();
        smc_n_cs16 = 1'b0;
        tick();
        do_read(4'd9, 32'h0, 4'd3, 32'h0);

        smc_n_cs16 = 1'b1;
        tick();
        chk("final_idle", 32'(rsp_state16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
